// File: rtl/barret_rr_sched_1483.sv
// Two-requester round-robin front end on a 2-stage Barrett reducer mod Q. Latency 2 cycles, 1 op/cycle.
// Backpressure: out_ready low freezes a full pipe and drops both req*_ready; a bubble in either stage is absorbed.
module barret_rr_sched_1483 #(
   parameter int Q    = 1483,
   parameter int MU   = 2828,
   parameter int K    = 11,
   parameter int IN_W = 21,
   parameter int OUT_W = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [IN_W-1:0]  req0_data,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [IN_W-1:0]  req1_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_tag
);

   localparam int R_W = 13;

   typedef struct packed {
      logic            vld;
      logic            tag;
      logic [IN_W-1:0] a;
      logic [K-1:0]    t;
   } s1_reg_t;

   typedef struct packed {
      logic             vld;
      logic             tag;
      logic [OUT_W-1:0] res;
   } s2_reg_t;

   s1_reg_t s1;
   s2_reg_t s2;
   logic    rr_ptr;

   logic            adv1, adv2, grant0, grant1, accept;
   logic [IN_W-1:0] sel_a;
   logic [K-1:0]    q, t_new;
   logic [2*K-1:0]  prod;
   logic [IN_W-1:0] tq;
   logic [R_W-1:0]  r, r_red;

   assign adv2 = !s2.vld || out_ready;
   assign adv1 = !s1.vld || adv2;

   assign grant0     = req0_valid && (!rr_ptr || !req1_valid);
   assign grant1     = req1_valid && !grant0;
   assign req0_ready = grant0 && adv1 && !rst;
   assign req1_ready = grant1 && adv1 && !rst;
   assign accept     = req0_ready || req1_ready;

   // Stage 1: quotient estimate t = ((a >> K) * MU) >> K at full 22-bit product width
   assign sel_a = grant1 ? req1_data : req0_data;
   assign q     = K'(sel_a >> K);
   assign prod  = (2*K)'(q) * (2*K)'(MU);
   assign t_new = K'(prod >> K);

   // Stage 2: r = a - t*Q is below 4Q, so its low 13 bits are exact
   assign tq = IN_W'(s1.t) * IN_W'(Q);
   assign r  = R_W'(s1.a - tq);

   always_comb begin
      r_red = r;
      if (r >= R_W'(3*Q))
         r_red = r - R_W'(3*Q);
      else if (r >= R_W'(2*Q))
         r_red = r - R_W'(2*Q);
      else if (r >= R_W'(Q))
         r_red = r - R_W'(Q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1     <= '0;
         s2     <= '0;
         rr_ptr <= 1'b0;
      end else begin
         if (adv2) begin
            s2.vld <= s1.vld;
            if (s1.vld) begin
               s2.tag <= s1.tag;
               s2.res <= OUT_W'(r_red);
            end
         end
         if (adv1) begin
            s1.vld <= accept;
            if (accept) begin
               s1.tag <= grant1;
               s1.a   <= sel_a;
               s1.t   <= t_new;
            end
         end
         if (accept)
            rr_ptr <= ~grant1;
      end
   end

   assign out_valid = s2.vld;
   assign out_data  = s2.res;
   assign out_tag   = s2.tag;

endmodule

// File: tb/tb_barret_rr_sched_1483.sv
// Bench for barret_rr_sched_1483: queue-based reference model checked every cycle, plus directed literal checks.
module tb_barret_rr_sched_1483;
   localparam int Q = 1483;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid, out_ready;
   logic        req0_ready, req1_ready, out_valid, out_tag;
   logic [20:0] req0_data, req1_data;
   logic [10:0] out_data;

   barret_rr_sched_1483 dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: in-flight items in acceptance order, each with the number of edges since it was accepted
   typedef struct {
      bit tag;
      int res;
      int age;
   } item_t;
   typedef struct {
      logic [31:0] d;
      logic        tag;
   } obs_t;

   item_t mq[$];
   obs_t  olog[$];
   bit    inited = 0;
   bit    m_rr = 0;
   int    acc0 = 0, acc1 = 0;
   int    w0 = 0, w1 = 0;

   always @(negedge clk) begin
      bit    eg0, eg1, can, er0, er1, eov;
      item_t it;
      obs_t  ob;
      eg0 = req0_valid && (!m_rr || !req1_valid);
      eg1 = req1_valid && !eg0;
      can = (mq.size() < 2) || out_ready;
      er0 = !rst && eg0 && can;
      er1 = !rst && eg1 && can;
      eov = (mq.size() > 0) && (mq[0].age >= 2);
      if (inited) begin
         chk("req0_ready", req0_ready, er0);
         chk("req1_ready", req1_ready, er1);
         chk("out_valid", out_valid, eov);
         if (eov) begin
            chk("out_data", out_data, mq[0].res);
            chk("out_tag", out_tag, mq[0].tag);
         end
         if (!rst) begin
            if (req1_valid && req1_ready && req0_valid) begin
               w0++;
               chk("starve0", w0 <= 1, 1);
            end else if ((req0_valid && req0_ready) || !req0_valid) w0 = 0;
            if (req0_valid && req0_ready && req1_valid) begin
               w1++;
               chk("starve1", w1 <= 1, 1);
            end else if ((req1_valid && req1_ready) || !req1_valid) w1 = 0;
            if (req0_valid && req0_ready) acc0++;
            if (req1_valid && req1_ready) acc1++;
            if (out_valid && out_ready) begin
               ob.d = 32'(out_data);
               ob.tag = out_tag;
               olog.push_back(ob);
            end
         end
      end
      if (rst) begin
         mq.delete();
         m_rr = 0;
         w0 = 0;
         w1 = 0;
         inited = 1;
      end else if (inited) begin
         if (eov && out_ready) void'(mq.pop_front());
         foreach (mq[i]) mq[i].age++;
         if (er0 || er1) begin
            it.tag = er1;
            it.res = er1 ? int'(req1_data) % Q : int'(req0_data) % Q;
            it.age = 1;
            mq.push_back(it);
            m_rr = !er1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int b0, b1;
   int edge_in [5] = '{0, 1482, 1483, 2966, 2097151};
   int edge_out[5] = '{0, 1482, 0, 0, 189};

   initial begin
      rst = 1'b1;
      req0_valid = 0; req1_valid = 0; out_ready = 0;
      req0_data = '0; req1_data = '0;
      step(); step();
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_tag", out_tag, 0);
      step();

      // Single op: latency two edges after the accept edge
      out_ready = 1; req0_valid = 1; req0_data = 21'd100000;
      @(negedge clk);
      chk("t1_ready", req0_ready, 1);
      step();
      req0_valid = 0;
      @(negedge clk);
      chk("t1_early_valid", out_valid, 0);
      @(negedge clk);
      chk("t1_out_valid", out_valid, 1);
      chk("t1_out_data", out_data, 639);
      chk("t1_out_tag", out_tag, 0);
      step();

      // Edge operands on requester 1, one per cycle
      olog.delete();
      b1 = acc1;
      req1_valid = 1; req1_data = 21'(edge_in[0]);
      repeat (10) begin
         step();
         if (acc1 - b1 < 5) req1_data = 21'(edge_in[acc1 - b1]);
         else req1_valid = 0;
      end
      chk("edge_count", olog.size(), 5);
      for (int i = 0; i < 5 && i < olog.size(); i++) begin
         chk("edge_data", olog[i].d, edge_out[i]);
         chk("edge_tag", olog[i].tag, 1);
      end

      // Backpressure: full pipe holds, then drains in order
      out_ready = 0; req0_valid = 1; req1_valid = 1;
      req0_data = 21'd5000; req1_data = 21'd7000;
      b0 = acc0 + acc1;
      repeat (5) step();
      chk("bp_accepts", acc0 + acc1 - b0, 2);
      @(negedge clk);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      step();
      olog.delete();
      req0_valid = 0; req1_valid = 0; out_ready = 1;
      repeat (6) step();
      chk("bp_drain_count", olog.size(), 2);
      if (olog.size() == 2) begin
         chk("bp_first", {olog[0].tag, olog[0].d[10:0]}, {1'b0, 11'd551});
         chk("bp_second", {olog[1].tag, olog[1].d[10:0]}, {1'b1, 11'd1068});
      end

      // Reset mid-stream with both stages occupied
      out_ready = 0; req0_valid = 1; req1_valid = 1;
      repeat (3) step();
      rst = 1;
      step();
      rst = 0; req0_valid = 0; req1_valid = 0; out_ready = 1;
      @(negedge clk);
      chk("mr_out_valid", out_valid, 0);
      olog.delete();
      repeat (4) step();
      chk("mr_no_stale", olog.size(), 0);

      // Fairness: both valid continuously, pointer starts at requester 0
      olog.delete();
      b0 = acc0; b1 = acc1;
      req0_valid = 1; req1_valid = 1;
      req0_data = 21'd10000; req1_data = 21'd20000;
      @(negedge clk);
      chk("fair_first_r0", req0_ready, 1);
      chk("fair_first_r1", req1_ready, 0);
      repeat (12) begin
         step();
         req0_data = 21'(10000 + acc0 - b0);
         req1_data = 21'(20000 + acc1 - b1);
      end
      req0_valid = 0; req1_valid = 0;
      repeat (4) step();
      chk("fair_count", olog.size(), 12);
      if (olog.size() >= 4) begin
         chk("fair_0", {olog[0].tag, olog[0].d[10:0]}, {1'b0, 11'd1102});
         chk("fair_1", {olog[1].tag, olog[1].d[10:0]}, {1'b1, 11'd721});
         chk("fair_2", {olog[2].tag, olog[2].d[10:0]}, {1'b0, 11'd1103});
         chk("fair_3", {olog[3].tag, olog[3].d[10:0]}, {1'b1, 11'd722});
      end

      // Random traffic with random backpressure
      repeat (10000) begin
         step();
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 9) < 7);
         req0_data  = ($urandom_range(0, 7) == 0) ? 21'h1FFFFF : 21'($urandom_range(0, 2097151));
         req1_data  = ($urandom_range(0, 7) == 0) ? 21'(Q) : 21'($urandom_range(0, 2097151));
      end
      req0_valid = 0; req1_valid = 0; out_ready = 1;
      repeat (5) step();
      chk("final_empty", mq.size(), 0);
      chk("final_out_valid", out_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/barret_rr_sched_1483.md
Name: barret_rr_sched_1483

Overview:
- Two-requester round-robin scheduler wrapped around a single pipelined Barrett reduction datapath, modulus 1483.
- Lets two producers, e.g. two NTT butterfly lanes, share one reducer.
- Accepts 21-bit operands through valid/ready handshakes and returns fully reduced 11-bit residues, in issue order, tagged with the source requester.
- Full backpressure from the consumer.

Parameters:
- Q, 1483, modulus
- MU, 2828, Barrett constant floor(2^(2K)/Q)
- K, 11, shift amount
- IN_W, 21, operand width
- OUT_W, 11, residue width

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 operand valid
- req0_ready  out  1  requester 0 operand accepted this cycle
- req0_data  in  IN_W  requester 0 operand
- req1_valid  in  1  requester 1 operand valid
- req1_ready  out  1  requester 1 operand accepted this cycle
- req1_data  in  IN_W  requester 1 operand
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  OUT_W  residue, range 0..Q-1
- out_tag  out  1  source requester of out_data (0/1)

Behaviour:
- Reset (synchronous, active-high): s1_valid=0, s2_valid=0, rr_ptr=0, out_valid=0, out_data=0, out_tag=0. req*_ready are combinational and read 0 while rst is high. Reset mid-operation drops all in-flight operands without emitting them.
- Pipeline, two register stages:
  - S1 register holds valid, tag, a and t. Here q=a>>K (11b), t=(q*MU)>>K, computed at full product width (22b) before the shift.
  - S2 register holds valid, tag and the residue. r=a - t*Q is 13b unsigned (r < 4*Q guaranteed). The residue is r - k*Q, where k = count of {r>=Q, r>=2Q, r>=3Q}. This yields exact a mod Q for every 21-bit a.
- Stall logic:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - S2 loads S1 when adv2; S1 loads the granted operand when adv1.
  - An S1 bubble sets s2_valid=0 when adv2.
- out_valid=s2_valid, out_data and out_tag driven from S2. These hold stable while out_valid && !out_ready.
- Latency: accept at edge N gives out_valid at edge N+2 when there is no backpressure. Throughput is 1 op/cycle.
- Arbitration:
  - grant0 = req0_valid && (rr_ptr==0 || !req1_valid); grant1 = req1_valid && !grant0.
  - reqX_ready = grantX && adv1 && !rst. At most one ready per cycle.
  - ready may depend combinationally on valid; valid must not depend on ready.
- rr_ptr update: on each accepted transfer, rr_ptr becomes the other requester. No transfer leaves rr_ptr unchanged.
- Fairness: with both valid continuously and no stall, grants alternate 0,1,0,1.
- Ordering: results leave in acceptance order; no reordering between tags.
- Boundaries:
  - Full pipe with out_ready=0: both readys are 0, and no state changes except the arbiter holding.
  - Simultaneous out handshake and new accept in the same cycle is legal and keeps full throughput.
  - a < Q passes through unchanged; a = 2^21-1 is legal.

Test Plan:
- Reset then single op: req0_data=100000, valid one cycle -> req0_ready=1 that cycle; out_valid two edges later with out_data=639, out_tag=0.
- Edge operands on req1: 0, 1482, 1483, 2966, 2097151 back-to-back -> outputs 0, 1482, 0, 0, 189, all tag 1, one per cycle.
- Both requesters continuously valid, out_ready=1, req0 = 10000+i, req1 = 20000+i -> grants alternate starting with req0; out_tag sequence 0,1,0,1; each residue equals operand mod 1483.
- Backpressure: hold out_ready=0 for 5 cycles with both requesters valid -> at most 2 accepts, then both readys 0; out_data/out_tag stable; on release, no loss or duplication, order preserved.
- Reset mid-stream: assert rst for one cycle while S1 and S2 are valid -> out_valid=0 next cycle, rr_ptr=0, and no stale result emitted afterwards.
- Random 10k operands with random valid/out_ready -> scoreboard matches a mod 1483 and per-tag order; a never-starved check shows no requester waits more than 1 grant while the other is served.
